tune_drive_arbiter: RTL and testbench

//  Shares the single PULSE stepper driver between the TR, TX and TP tuning regulators.

---
 rtl/tune_arb_pkg.sv | 21 ++
 rtl/tune_arb_pick.sv | 34 +++
 rtl/tune_drive_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_tune_drive_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tune_arb_pkg.sv
// tune_arb_pkg
// Shared constants for the tuning-drive arbiter: source indices for the TR, TX
// and TP regulators, the arbiter state encoding and the default data width.
package tune_arb_pkg;

  localparam int W_DEF = 32;

  // Source index, also the bit position in mode/req/ack/nak/gnt
  localparam logic [1:0] SRC_TR = 2'd0;
  localparam logic [1:0] SRC_TX = 2'd1;
  localparam logic [1:0] SRC_TP = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_ABORT,
    ST_GAP
  } state_t;

endpackage

// File: rtl/tune_arb_pick.sv
// tune_arb_pick
// Combinational fixed-priority picker, order TR > TP > TX.
// Ports:
//   eligible [2:0]  in   requesting and mode-enabled sources
//   onehot   [2:0]  out  winner as a one-hot vector (0 when none)
//   idx      [1:0]  out  winner index (SRC_TR when none)
//   any             out  at least one source is eligible
module tune_arb_pick
  import tune_arb_pkg::*;
(
  input  logic [2:0] eligible,
  output logic [2:0] onehot,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    onehot = 3'b000;
    idx    = SRC_TR;
    any    = |eligible;
    // TP outranks TX even though its index is higher
    if (eligible[SRC_TR]) begin
      onehot[SRC_TR] = 1'b1;
      idx            = SRC_TR;
    end else if (eligible[SRC_TP]) begin
      onehot[SRC_TP] = 1'b1;
      idx            = SRC_TP;
    end else if (eligible[SRC_TX]) begin
      onehot[SRC_TX] = 1'b1;
      idx            = SRC_TX;
    end
  end

endmodule

// File: rtl/tune_drive_arbiter.sv
// tune_drive_arbiter
// Shares the single PULSE stepper driver between the TR, TX and TP regulators.
// Picks a requester (TR > TP > TX), validates and latches its job, starts PULSE,
// supervises the run (done / mode drop / watchdog), aborts when needed, and then
// holds a dead time before the next grant.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mode[2:0], req[2:0]      per-source enable and request level (0=TR,1=TX,2=TP)
//   req_L/F1/F2[3*W-1:0]     per-source job parameters, slice i = [i*W +: W]
//   ack/nak[2:0]             one-cycle accept / reject pulses
//   gnt[2:0]                 one-hot driver owner, held through the run
//   drv_start, drv_abort     one-cycle command pulses to PULSE
//   drv_L/F1/F2[W-1:0]       latched job parameters
//   drv_busy, drv_done       PULSE status
//   busy                     arbiter not idle
//   err_tmo                  sticky watchdog flag, cleared by the next ack
module tune_drive_arbiter
  import tune_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int GAP_CYC = 50,
  parameter int TMO_CYC = 2500000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     mode,
  input  logic [2:0]     req,
  input  logic [3*W-1:0] req_L,
  input  logic [3*W-1:0] req_F1,
  input  logic [3*W-1:0] req_F2,
  output logic [2:0]     ack,
  output logic [2:0]     nak,
  output logic [2:0]     gnt,
  output logic           drv_start,
  output logic           drv_abort,
  output logic [W-1:0]   drv_L,
  output logic [W-1:0]   drv_F1,
  output logic [W-1:0]   drv_F2,
  input  logic           drv_busy,
  input  logic           drv_done,
  output logic           busy,
  output logic           err_tmo
);

  localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [W-1:0]  TMO_MAX  = W'(TMO_CYC);

  logic [2:0]   elig, win_oh;
  logic [1:0]   win_idx;
  logic         win_any;
  logic [W-1:0] win_L, win_F1, win_F2;
  logic [W-1:0] wdog_inc;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [2:0]    gnt_q, gnt_d, ack_q, ack_d, nak_q, nak_d;
  logic          start_q, start_d, abort_q, abort_d, err_q, err_d;
  logic [W-1:0]  l_q, l_d, f1_q, f1_d, f2_q, f2_d;
  logic [W-1:0]  wdog_q, wdog_d;
  logic [GW-1:0] gap_q, gap_d;

  assign elig = req & mode;

  tune_arb_pick u_pick (
    .eligible (elig),
    .onehot   (win_oh),
    .idx      (win_idx),
    .any      (win_any)
  );

  assign win_L    = req_L [int'(win_idx)*W +: W];
  assign win_F1   = req_F1[int'(win_idx)*W +: W];
  assign win_F2   = req_F2[int'(win_idx)*W +: W];
  // Saturating increment: the watchdog never wraps back under the limit
  assign wdog_inc = (wdog_q == TMO_MAX) ? TMO_MAX : wdog_q + W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    ack_d   = 3'b000;
    nak_d   = 3'b000;
    start_d = 1'b0;
    abort_d = 1'b0;
    err_d   = err_q;
    l_d     = l_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        // A rejected source still holds req during its nak cycle; skipping
        // arbitration for that one cycle prevents a duplicate nak.
        if (win_any && (nak_q == 3'b000)) begin
          if (win_F1 > win_F2) begin
            nak_d = win_oh;
          end else if (win_L == '0) begin
            ack_d   = win_oh;
            err_d   = 1'b0;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            ack_d   = win_oh;
            start_d = 1'b1;
            err_d   = 1'b0;
            gnt_d   = win_oh;
            owner_d = win_idx;
            l_d     = win_L;
            f1_d    = win_F1;
            f2_d    = win_F2;
            wdog_d  = '0;
            state_d = ST_LOAD;
          end
        end
      end
      // LOAD is the ack/drv_start cycle; it supervises exactly like RUN
      ST_LOAD, ST_RUN: begin
        wdog_d = wdog_inc;
        if (drv_done) begin
          gnt_d   = 3'b000;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (!mode[owner_q]) begin
          abort_d = 1'b1;
          state_d = ST_ABORT;
        end else if (wdog_inc == TMO_MAX) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = ST_ABORT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ABORT: begin
        // Let PULSE see the abort pulse before trusting drv_busy
        if (!abort_q && !drv_busy) begin
          gnt_d   = 3'b000;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= SRC_TR;
      gnt_q   <= 3'b000;
      ack_q   <= 3'b000;
      nak_q   <= 3'b000;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      l_q     <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      wdog_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      nak_q   <= nak_d;
      start_q <= start_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      l_q     <= l_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
    end
  end

  assign ack       = ack_q;
  assign nak       = nak_q;
  assign gnt       = gnt_q;
  assign drv_start = start_q;
  assign drv_abort = abort_q;
  assign drv_L     = l_q;
  assign drv_F1    = f1_q;
  assign drv_F2    = f2_q;
  assign err_tmo   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tune_drive_arbiter.sv
// Testbench for tune_drive_arbiter: directed scenarios plus a randomized phase,
// all checked every cycle against a job-level behavioural model.
module tb_tune_drive_arbiter;

  localparam int W       = 32;
  localparam int GAP_CYC = 4;
  localparam int TMO_CYC = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [2:0]     mode = 3'b000;
  logic [2:0]     req = 3'b000;
  logic [W-1:0]   s_L[3], s_F1[3], s_F2[3];
  logic [3*W-1:0] req_L, req_F1, req_F2;
  logic [2:0]     ack, nak, gnt;
  logic           drv_start, drv_abort, drv_busy = 1'b0, drv_done = 1'b0;
  logic [W-1:0]   drv_L, drv_F1, drv_F2;
  logic           busy, err_tmo;

  assign req_L  = {s_L[2],  s_L[1],  s_L[0]};
  assign req_F1 = {s_F1[2], s_F1[1], s_F1[0]};
  assign req_F2 = {s_F2[2], s_F2[1], s_F2[0]};

  tune_drive_arbiter #(.W(W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .mode(mode), .req(req),
    .req_L(req_L), .req_F1(req_F1), .req_F2(req_F2),
    .ack(ack), .nak(nak), .gnt(gnt),
    .drv_start(drv_start), .drv_abort(drv_abort),
    .drv_L(drv_L), .drv_F1(drv_F1), .drv_F2(drv_F2),
    .drv_busy(drv_busy), .drv_done(drv_done),
    .busy(busy), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (job level) ----------------
  int           m_owner = -1;   // source owning the driver, -1 if none
  int           m_age   = 0;    // clocks since the job was granted
  int           m_cool  = 0;    // dead-time clocks still to run
  bit           m_abrt  = 1'b0; // job is being aborted
  int           m_w;
  int           ord[3] = '{0, 2, 1};
  logic [2:0]   e_ack = '0, e_nak = '0, e_gnt = '0, n_ack, n_nak;
  logic         e_start = 1'b0, e_abort = 1'b0, e_err = 1'b0, e_busy = 1'b0, n_st, n_ab;
  logic [W-1:0] e_L = '0, e_F1 = '0, e_F2 = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = -1; m_age = 0; m_cool = 0; m_abrt = 1'b0;
      e_ack = '0; e_nak = '0; e_gnt = '0; e_start = 1'b0; e_abort = 1'b0;
      e_err = 1'b0; e_busy = 1'b0; e_L = '0; e_F1 = '0; e_F2 = '0;
    end else begin
      n_ack = '0; n_nak = '0; n_st = 1'b0; n_ab = 1'b0;
      if (m_owner < 0 && m_cool == 0) begin
        m_w = -1;
        if (e_nak == 3'b000)
          for (int k = 0; k < 3; k++)
            if (m_w < 0 && req[ord[k]] && mode[ord[k]]) m_w = ord[k];
        if (m_w >= 0) begin
          if (s_F1[m_w] > s_F2[m_w]) n_nak[m_w] = 1'b1;
          else begin
            n_ack[m_w] = 1'b1;
            e_err = 1'b0;
            if (s_L[m_w] == 0) m_cool = GAP_CYC;
            else begin
              m_owner = m_w; m_age = 0; n_st = 1'b1;
              e_L = s_L[m_w]; e_F1 = s_F1[m_w]; e_F2 = s_F2[m_w];
            end
          end
        end
      end else if (m_owner >= 0 && !m_abrt) begin
        m_age++;
        if (drv_done) begin m_owner = -1; m_cool = GAP_CYC; end
        else if (!mode[m_owner]) begin m_abrt = 1'b1; n_ab = 1'b1; end
        else if (m_age >= TMO_CYC) begin m_abrt = 1'b1; n_ab = 1'b1; e_err = 1'b1; end
      end else if (m_abrt) begin
        if (!e_abort && !drv_busy) begin m_abrt = 1'b0; m_owner = -1; m_cool = GAP_CYC; end
      end else begin
        m_cool--;
      end
      e_ack = n_ack; e_nak = n_nak; e_start = n_st; e_abort = n_ab;
      e_gnt = 3'b000;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
      e_busy = (m_owner >= 0) || (m_cool > 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ack",       32'(ack),       32'(e_ack));
      check("nak",       32'(nak),       32'(e_nak));
      check("gnt",       32'(gnt),       32'(e_gnt));
      check("drv_start", 32'(drv_start), 32'(e_start));
      check("drv_abort", 32'(drv_abort), 32'(e_abort));
      check("drv_L",     drv_L,          e_L);
      check("drv_F1",    drv_F1,         e_F1);
      check("drv_F2",    drv_F2,         e_F2);
      check("busy",      32'(busy),      32'(e_busy));
      check("err_tmo",   32'(err_tmo),   32'(e_err));
    end
  end

  // ---------------- stimulus: sources and PULSE driver ----------------
  bit rnd_on    = 1'b0;
  int pulse_dur = 10;  // start-to-done clocks, 0 = never finishes
  int abort_lat = 1;   // abort-to-busy-low clocks (>=1)
  int p_left    = -1;
  int p_ab      = 0;

  task automatic new_params(input int i);
    logic [31:0] a, b;
    s_L[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
    a = 32'($urandom_range(1000, 60000));
    b = 32'($urandom_range(1000, 60000));
    if ($urandom_range(0, 3) == 0) begin
      s_F1[i] = (a > b) ? a : b; s_F2[i] = (a > b) ? b : a;
    end else begin
      s_F1[i] = (a > b) ? b : a; s_F2[i] = (a > b) ? a : b;
    end
  endtask

  task automatic tick();
    logic [2:0] seen;
    logic st, ab;
    int dur, lat;
    seen = ack | nak; st = drv_start; ab = drv_abort;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 3; i++) if (seen[i]) req[i] = 1'b0;
    drv_done = 1'b0;
    if (!rst) begin
      drv_busy = 1'b0; p_left = -1; p_ab = 0;
    end else if (st) begin
      dur = rnd_on ? (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 60))) : pulse_dur;
      drv_busy = 1'b1; p_left = (dur == 0) ? -1 : dur - 1; p_ab = 0;
    end else if (ab) begin
      lat = rnd_on ? int'($urandom_range(1, 4)) : abort_lat;
      p_left = -1; p_ab = lat - 1;
      if (p_ab == 0) drv_busy = 1'b0;
    end else if (p_ab > 0) begin
      p_ab--;
      if (p_ab == 0) drv_busy = 1'b0;
    end else if (p_left > 0) begin
      p_left--;
      if (p_left == 0) begin drv_done = 1'b1; drv_busy = 1'b0; p_left = -1; end
    end
    if (rnd_on) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && !seen[i] && $urandom_range(0, 7) == 0) begin
          new_params(i); req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end
        if (mode[i] && $urandom_range(0, 149) == 0) mode[i] = 1'b0;
        else if (!mode[i] && $urandom_range(0, 7) == 0) mode[i] = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || drv_busy) && n < 500) begin tick(); n++; end
    if (busy || drv_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", nm, n);
    end
  endtask

  task automatic set_job(input int i, input logic [31:0] l, input logic [31:0] f1, input logic [31:0] f2);
    s_L[i] = l; s_F1[i] = f1; s_F2[i] = f2; req[i] = 1'b1;
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    return (v == 3'b001) ? 0 : (v == 3'b010) ? 1 : (v == 3'b100) ? 2 : 7;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  int  got_ord[3];
  int  starts, last_done, min_gap, n;
  bit  gnt_ok;

  initial begin
    for (int i = 0; i < 3; i++) begin s_L[i] = '0; s_F1[i] = '0; s_F2[i] = '0; end
    tick(); tick();
    cmp_en = 1'b1;
    check("reset_outputs", 32'({ack, nak, gnt, drv_start, drv_abort, busy, err_tmo}), 32'd0);
    check("reset_drv_L", drv_L, 32'd0);
    rst = 1'b1; mode = 3'b111;
    tick();

    // 1: single TR job
    pulse_dur = 30;
    set_job(0, 16, 6000, 50000);
    tick();
    check("t1_ack", 32'(ack), 32'b001);
    check("t1_model_ack", 32'(e_ack), 32'b001);
    check("t1_start", 32'(drv_start), 32'd1);
    check("t1_drv_L", drv_L, 32'd16);
    check("t1_drv_F2", drv_F2, 32'd50000);
    gnt_ok = 1'b1; n = 0;
    while (!drv_done && n < 60) begin
      tick(); n++;
      if (gnt !== 3'b001) gnt_ok = 1'b0;
    end
    check("t1_done_after_30", 32'(n), 32'd30);
    check("t1_gnt_held", 32'(gnt_ok), 32'd1);
    tick();
    check("t1_gnt_cleared", 32'(gnt), 32'd0);
    tick(); tick(); tick();
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    tick();
    check("t1_busy_low", 32'(busy), 32'd0);
    wait_idle("t1_idle");

    // 2: simultaneous requests served TR, TP, TX
    pulse_dur = 10;
    set_job(0, 100, 1000, 2000); set_job(1, 200, 1000, 2000); set_job(2, 300, 1000, 2000);
    starts = 0; last_done = -1; min_gap = 1000;
    for (int k = 0; k < 300 && !(starts == 3 && !busy); k++) begin
      tick();
      if (drv_done) last_done = cyc;
      if (drv_start) begin
        if (starts < 3) got_ord[starts] = oh_idx(gnt);
        if (last_done >= 0 && cyc - last_done < min_gap) min_gap = cyc - last_done;
        starts++;
      end
    end
    check("t2_starts", 32'(starts), 32'd3);
    check("t2_first_TR", 32'(got_ord[0]), 32'd0);
    check("t2_second_TP", 32'(got_ord[1]), 32'd2);
    check("t2_third_TX", 32'(got_ord[2]), 32'd1);
    check("t2_gap_ge5", 32'(min_gap >= 5), 32'd1);
    wait_idle("t2_idle");

    // 3: TX mode dropped during run
    pulse_dur = 0; abort_lat = 3;
    set_job(1, 50, 3000, 4000);
    tick(); tick(); tick(); tick(); tick();
    mode[1] = 1'b0;
    tick();
    check("t3_abort", 32'(drv_abort), 32'd1);
    tick();
    check("t3_abort_one_pulse", 32'(drv_abort), 32'd0);
    tick(); tick();
    check("t3_gnt_until_busy_low", 32'(gnt), 32'b010);
    tick();
    check("t3_gnt_cleared", 32'(gnt), 32'd0);
    check("t3_no_err", 32'(err_tmo), 32'd0);
    mode = 3'b111;
    wait_idle("t3_idle");

    // 4: TP watchdog timeout
    pulse_dur = 0; abort_lat = 2;
    set_job(2, 77, 100, 200);
    tick();
    check("t4_start", 32'(drv_start), 32'd1);
    repeat (99) tick();
    check("t4_no_err_at_99", 32'(err_tmo), 32'd0);
    tick();
    check("t4_err_at_100", 32'(err_tmo), 32'd1);
    check("t4_model_err", 32'(e_err), 32'd1);
    check("t4_abort_at_100", 32'(drv_abort), 32'd1);
    wait_idle("t4_idle");
    check("t4_err_sticky", 32'(err_tmo), 32'd1);
    pulse_dur = 5;
    set_job(0, 8, 10, 20);
    tick();
    check("t4_next_ack", 32'(ack), 32'b001);
    check("t4_err_cleared", 32'(err_tmo), 32'd0);
    wait_idle("t4_idle2");

    // 5: rejection and zero-length job
    set_job(0, 10, 50000, 6000);
    tick();
    check("t5_nak", 32'(nak), 32'b001);
    check("t5_no_ack", 32'(ack), 32'd0);
    check("t5_no_start", 32'(drv_start), 32'd0);
    tick();
    check("t5_nak_single", 32'(nak), 32'd0);
    tick();
    set_job(1, 0, 1000, 2000);
    tick();
    check("t5_zero_ack", 32'(ack), 32'b010);
    check("t5_zero_no_start", 32'(drv_start), 32'd0);
    check("t5_zero_gap", 32'(busy), 32'd1);
    check("t5_zero_no_gnt", 32'(gnt), 32'd0);
    wait_idle("t5_idle");

    // 6: reset during run, pending request granted afterwards
    pulse_dur = 0;
    set_job(0, 100, 1000, 2000);
    repeat (6) tick();
    set_job(0, 7, 1100, 2100);
    rst = 1'b0;
    #1;
    check("t6_reset_outputs", 32'({ack, nak, gnt, drv_start, drv_abort, busy, err_tmo}), 32'd0);
    check("t6_reset_drv_L", drv_L, 32'd0);
    tick(); tick();
    rst = 1'b1;
    pulse_dur = 6;
    tick();
    check("t6_ack_after_reset", 32'(ack), 32'b001);
    check("t6_start_after_reset", 32'(drv_start), 32'd1);
    check("t6_drv_L", drv_L, 32'd7);
    wait_idle("t6_idle");

    // randomized traffic, with one reset in the middle
    rnd_on = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) rst = 1'b0;
      if (k == 1503) rst = 1'b1;
      tick();
    end
    rnd_on = 1'b0;
    req = 3'b000; mode = 3'b111;
    wait_idle("rand_idle");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
